// File: rtl/reg_exec_ctrl_if.sv
// Instruction handshake and register-file port bundle for reg_exec_ctrl.
// The slave modport is the controller side.
// The master modport is the CPU/register-file side that feeds it.
interface reg_exec_ctrl_if;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        in_ready;
    logic [2:0]  rf_rd0_addr;
    logic [2:0]  rf_rd1_addr;
    logic [15:0] rf_rd0_data;
    logic [15:0] rf_rd1_data;
    logic        rf_wr_en;
    logic [2:0]  rf_wr_addr;
    logic [15:0] rf_wr_data;
    logic        done;
    logic        flag_z;
    logic        flag_c;
    logic        err;

    modport slave (
        input  in_valid, in_instr, rf_rd0_data, rf_rd1_data,
        output in_ready, rf_rd0_addr, rf_rd1_addr, rf_wr_en, rf_wr_addr,
               rf_wr_data, done, flag_z, flag_c, err
    );

    modport master (
        output in_valid, in_instr, rf_rd0_data, rf_rd1_data,
        input  in_ready, rf_rd0_addr, rf_rd1_addr, rf_wr_en, rf_wr_addr,
               rf_wr_data, done, flag_z, flag_c, err
    );
endinterface

// File: rtl/reg_exec_ctrl.sv
// Execute/write-back controller sitting between the read ports and the write port
// of the 8x16 register file. Each instruction runs through IDLE -> READ -> EXEC -> WB.
// A handshake taken during WB goes straight back to READ.
// Optional feature macro REG_EXEC_SAT_EN: ADD/ADDI saturate to 16'hFFFF on carry
// and SUB saturates to 16'h0000 on borrow. Without the macro, results wrap.
module reg_exec_ctrl #(
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    reg_exec_ctrl_if.slave  bus
);

`ifdef REG_EXEC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_NOT  = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_SHR  = 4'd8;
    localparam logic [3:0] OP_ADDI = 4'd9;
    localparam logic [3:0] OP_LDI  = 4'd10;

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t      state, state_nxt;
    logic [15:0] instr_q;
    logic [15:0] result_q;
    logic        z_pend, c_pend;
    logic        flag_z_q, flag_c_q;
    logic        err_q;

    logic [3:0]  op;
    logic        op_write, op_illegal, op_carry;
    logic        hs;
    logic [16:0] alu_raw;
    logic [15:0] alu_res;

    logic        in_ready_c, wr_en_c, done_c, err_c;

    // Raw ALU: bit 16 carries the carry (ADD/ADDI) or the borrow (SUB).
    function automatic logic [16:0] alu_op(input logic [3:0] opc, input logic [15:0] a,
                                           input logic [15:0] b, input logic [8:0] imm);
        logic [16:0] r;
        r = 17'd0;
        case (opc)
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_SUB:  r = {1'b0, a} - {1'b0, b};
            OP_AND:  r = {1'b0, a & b};
            OP_OR:   r = {1'b0, a | b};
            OP_XOR:  r = {1'b0, a ^ b};
            OP_NOT:  r = {1'b0, ~a};
            OP_SHL:  r = {1'b0, a << b[3:0]};
            OP_SHR:  r = {1'b0, a >> b[3:0]};
            OP_ADDI: r = {1'b0, a} + {11'd0, imm[5:0]};
            OP_LDI:  r = {8'd0, imm};
            default: r = 17'd0;
        endcase
        return r;
    endfunction

    // Clamp ADD/ADDI on carry and SUB on borrow when saturation is built in.
    function automatic logic [15:0] sat_result(input logic [3:0] opc, input logic [16:0] raw);
        logic [15:0] r;
        r = raw[15:0];
        if (SAT_EN && raw[16] && (opc == OP_ADD || opc == OP_ADDI))
            r = 16'hFFFF;
        else if (SAT_EN && raw[16] && opc == OP_SUB)
            r = 16'h0000;
        return r;
    endfunction

    assign op         = instr_q[15:12];
    assign op_write   = (op != OP_NOP) && (op <= OP_LDI);
    assign op_illegal = (op > OP_LDI);
    assign op_carry   = (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI);
    assign hs         = bus.in_valid && in_ready_c;
    assign alu_raw    = alu_op(op, bus.rf_rd0_data, bus.rf_rd1_data, instr_q[8:0]);
    assign alu_res    = sat_result(op, alu_raw);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: a WB handshake chains directly into the next READ.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hs) state_nxt = READ;
            READ:    state_nxt = EXEC;
            EXEC:    state_nxt = WB;
            WB:      state_nxt = hs ? READ : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Instruction latch, result/flag staging in EXEC, flag commit and sticky error in WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q  <= 16'd0;
            result_q <= 16'd0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (hs)
                instr_q <= bus.in_instr;
            if (state == EXEC)
                result_q <= alu_res;
            if (state == WB) begin
                if (op_write) flag_z_q <= z_pend;
                if (op_carry) flag_c_q <= c_pend;
                if (ILLEGAL_HALT && op_illegal) err_q <= 1'b1;
            end
        end
    end

    // Pending flags; they are only consumed in the WB that follows EXEC.
    always_ff @(posedge clk) begin
        if (state == EXEC) begin
            z_pend <= (alu_res == 16'd0);
            c_pend <= alu_raw[16];
        end
    end

    // Output decode from the current state.
    always_comb begin
        in_ready_c = 1'b0;
        wr_en_c    = 1'b0;
        done_c     = 1'b0;
        err_c      = err_q;
        case (state)
            IDLE: in_ready_c = !err_q;
            WB: begin
                done_c     = 1'b1;
                wr_en_c    = op_write;
                err_c      = err_q || op_illegal;
                in_ready_c = !(err_q || (ILLEGAL_HALT && op_illegal));
            end
            default: ;
        endcase
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.rf_rd0_addr = instr_q[8:6];
    assign bus.rf_rd1_addr = instr_q[5:3];
    assign bus.rf_wr_en    = wr_en_c;
    assign bus.rf_wr_addr  = instr_q[11:9];
    assign bus.rf_wr_data  = result_q;
    assign bus.done        = done_c;
    assign bus.flag_z      = flag_z_q;
    assign bus.flag_c      = flag_c_q;
    assign bus.err         = err_c;

endmodule

// File: tb/tb_reg_exec_ctrl.sv
// Directed bench for reg_exec_ctrl with a behavioural 8x16 register file.
// u_dut runs with ILLEGAL_HALT=0; u_halt runs with ILLEGAL_HALT=1 for the sticky-error case.
module tb_reg_exec_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nmis = 0;

    reg_exec_ctrl_if bus0();
    reg_exec_ctrl_if bus1();

    reg_exec_ctrl #(.ILLEGAL_HALT(1'b0)) u_dut  (.clk(clk), .rst(rst), .bus(bus0));
    reg_exec_ctrl #(.ILLEGAL_HALT(1'b1)) u_halt (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    logic [15:0] mem [8];

    // Register file model: registered reads that update only on non-write edges.
    always @(posedge clk) begin
        if (bus0.rf_wr_en) begin
            mem[bus0.rf_wr_addr] <= bus0.rf_wr_data;
        end else begin
            bus0.rf_rd0_data <= mem[bus0.rf_rd0_addr];
            bus0.rf_rd1_data <= mem[bus0.rf_rd1_addr];
        end
    end

`ifdef REG_EXEC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] enc_r(input int op, input int rd, input int rs0, input int rs1);
        return {op[3:0], rd[2:0], rs0[2:0], rs1[2:0], 3'b000};
    endfunction

    function automatic logic [15:0] enc_i6(input int op, input int rd, input int rs0, input int imm);
        return {op[3:0], rd[2:0], rs0[2:0], imm[5:0]};
    endfunction

    function automatic logic [15:0] enc_i9(input int op, input int rd, input int imm);
        return {op[3:0], rd[2:0], imm[8:0]};
    endfunction

    // Starts on a negedge in IDLE and ends on the negedge of the following IDLE cycle.
    task automatic exec_instr(input string tag, input logic [15:0] instr, input logic exp_we,
                              input logic [15:0] exp_data, input logic exp_err);
        check({tag, ".ready"}, bus0.in_ready, 1);
        bus0.in_valid = 1'b1;
        bus0.in_instr = instr;
        @(negedge clk);
        bus0.in_valid = 1'b0;
        check({tag, ".read_we"}, bus0.rf_wr_en, 0);
        check({tag, ".read_ready"}, bus0.in_ready, 0);
        check({tag, ".read_addr0"}, bus0.rf_rd0_addr, instr[8:6]);
        @(negedge clk);
        check({tag, ".exec_done"}, bus0.done, 0);
        @(negedge clk);
        check({tag, ".wb_done"}, bus0.done, 1);
        check({tag, ".wb_we"}, bus0.rf_wr_en, exp_we);
        check({tag, ".wb_err"}, bus0.err, exp_err);
        if (exp_we) begin
            check({tag, ".wb_addr"}, bus0.rf_wr_addr, instr[11:9]);
            check({tag, ".wb_data"}, bus0.rf_wr_data, exp_data);
        end
        @(negedge clk);
        check({tag, ".idle_done"}, bus0.done, 0);
    endtask

    task automatic chk_flags(input string tag, input logic z, input logic c);
        check({tag, ".z"}, bus0.flag_z, z);
        check({tag, ".c"}, bus0.flag_c, c);
    endtask

    logic [15:0] b2b [4];

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 16'd0;
        bus0.in_valid = 1'b0; bus0.in_instr = 16'd0;
        bus0.rf_rd0_data = 16'd0; bus0.rf_rd1_data = 16'd0;
        bus1.in_valid = 1'b0; bus1.in_instr = 16'd0;
        bus1.rf_rd0_data = 16'd0; bus1.rf_rd1_data = 16'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst.ready", bus0.in_ready, 1);
        check("rst.we", bus0.rf_wr_en, 0);
        check("rst.wr_addr", bus0.rf_wr_addr, 0);
        check("rst.wr_data", bus0.rf_wr_data, 0);
        check("rst.rd0", bus0.rf_rd0_addr, 0);
        check("rst.rd1", bus0.rf_rd1_addr, 0);
        check("rst.done", bus0.done, 0);
        check("rst.err", bus0.err, 0);
        chk_flags("rst", 0, 0);

        exec_instr("ldi_r0", enc_i9(10, 0, 0), 1, 16'h0000, 0);
        chk_flags("ldi_r0", 1, 0);
        exec_instr("not_r1", enc_r(6, 1, 0, 0), 1, 16'hFFFF, 0);
        chk_flags("not_r1", 0, 0);
        exec_instr("addi_r2", enc_i6(9, 2, 0, 1), 1, 16'h0001, 0);
        chk_flags("addi_r2", 0, 0);

        exec_instr("add_r3", enc_r(1, 3, 1, 2), 1, SAT ? 16'hFFFF : 16'h0000, 0);
        chk_flags("add_r3", SAT ? 1'b0 : 1'b1, 1);
        check("mem_r3", mem[3], SAT ? 16'hFFFF : 16'h0000);

        exec_instr("sub_r4", enc_r(2, 4, 2, 1), 1, SAT ? 16'h0000 : 16'h0002, 0);
        chk_flags("sub_r4", SAT ? 1'b1 : 1'b0, 1);

        exec_instr("ldi_r5", enc_i9(10, 5, 9'h1AB), 1, 16'h01AB, 0);
        chk_flags("ldi_r5", 0, 1);
        exec_instr("ldi_r7", enc_i9(10, 7, 4), 1, 16'h0004, 0);
        exec_instr("shl_r6", enc_r(7, 6, 5, 7), 1, 16'h1AB0, 0);
        check("mem_r6", mem[6], 16'h1AB0);
        exec_instr("shr_r3", enc_r(8, 3, 6, 7), 1, 16'h01AB, 0);
        exec_instr("xor_r3", enc_r(5, 3, 5, 5), 1, 16'h0000, 0);
        chk_flags("xor_r3", 1, 1);
        exec_instr("and_r3", enc_r(3, 3, 5, 1), 1, 16'h01AB, 0);
        exec_instr("or_r3", enc_r(4, 3, 5, 6), 1, 16'h1BBB, 0);
        chk_flags("or_r3", 0, 1);

        exec_instr("nop", 16'h0000, 0, 16'h0000, 0);
        chk_flags("nop", 0, 1);
        exec_instr("illegal", 16'hC000, 0, 16'h0000, 1);
        check("illegal.err_clear", bus0.err, 0);
        check("illegal.ready", bus0.in_ready, 1);
        chk_flags("illegal", 0, 1);
        exec_instr("sub_eq", enc_r(2, 3, 5, 5), 1, 16'h0000, 0);
        chk_flags("sub_eq", 1, 0);

        // Back-to-back ADDI with in_valid held high.
        b2b[0] = enc_i6(9, 1, 0, 10);
        b2b[1] = enc_i6(9, 2, 0, 20);
        b2b[2] = enc_i6(9, 3, 0, 30);
        b2b[3] = enc_i6(9, 4, 0, 40);
        bus0.in_valid = 1'b1;
        bus0.in_instr = b2b[0];
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("b2b.read_ready", bus0.in_ready, 0);
            check("b2b.read_we", bus0.rf_wr_en, 0);
            @(negedge clk);
            check("b2b.exec_ready", bus0.in_ready, 0);
            check("b2b.exec_done", bus0.done, 0);
            @(negedge clk);
            check("b2b.wb_ready", bus0.in_ready, 1);
            check("b2b.wb_done", bus0.done, 1);
            check("b2b.wb_we", bus0.rf_wr_en, 1);
            check("b2b.wb_addr", bus0.rf_wr_addr, i + 1);
            check("b2b.wb_data", bus0.rf_wr_data, 10 * (i + 1));
            if (i < 3) bus0.in_instr = b2b[i + 1];
            else       bus0.in_valid = 1'b0;
        end
        @(negedge clk);
        check("b2b.idle_ready", bus0.in_ready, 1);
        check("b2b.idle_done", bus0.done, 0);
        check("b2b.mem_r1", mem[1], 16'd10);
        check("b2b.mem_r4", mem[4], 16'd40);

        // Reset during EXEC of ADD r3,r1,r4 aborts the write.
        bus0.in_valid = 1'b1;
        bus0.in_instr = enc_r(1, 3, 1, 4);
        @(negedge clk);
        bus0.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstx.we", bus0.rf_wr_en, 0);
        check("rstx.done", bus0.done, 0);
        check("rstx.ready", bus0.in_ready, 1);
        check("rstx.wr_data", bus0.rf_wr_data, 0);
        check("rstx.wr_addr", bus0.rf_wr_addr, 0);
        chk_flags("rstx", 0, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rstx.mem_r3", mem[3], 16'd30);

        // Sticky illegal-opcode halt.
        check("halt.ready0", bus1.in_ready, 1);
        bus1.in_valid = 1'b1;
        bus1.in_instr = 16'hC000;
        @(negedge clk);
        bus1.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("halt.wb_err", bus1.err, 1);
        check("halt.wb_done", bus1.done, 1);
        check("halt.wb_ready", bus1.in_ready, 0);
        check("halt.wb_we", bus1.rf_wr_en, 0);
        @(negedge clk);
        check("halt.err_hold", bus1.err, 1);
        check("halt.ready_hold", bus1.in_ready, 0);
        bus1.in_valid = 1'b1;
        bus1.in_instr = enc_i9(10, 1, 5);
        repeat (4) @(negedge clk);
        check("halt.err_late", bus1.err, 1);
        check("halt.ready_late", bus1.in_ready, 0);
        check("halt.done_late", bus1.done, 0);
        bus1.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("halt.rst_err", bus1.err, 0);
        check("halt.rst_ready", bus1.in_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/reg_exec_ctrl.md
Name: reg_exec_ctrl

Overview:
- Multi-cycle execute/write-back controller directly downstream of the 8x16 register file's read ports and upstream of its write port.
- Accepts one 16-bit instruction per handshake and drives the register file read addresses.
- Consumes the registered read data, computes a 16-bit ALU result and writes it back through wr_en/wr_addr/wr_data.
- Provides the datapath sequencing for the lab CPU.

Parameters:
- ILLEGAL_HALT, 0, 1 = an illegal opcode sets err and holds in_ready low until rst; 0 = err pulses for one cycle and operation continues.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  instruction valid.
- in_instr  input  16  instruction: [15:12] op, [11:9] rd, [8:6] rs0, [5:3] rs1, [5:0] imm6, [8:0] imm9.
- in_ready  output  1  controller can accept an instruction.
- rf_rd0_addr  output  3  to register file rd0_addr.
- rf_rd1_addr  output  3  to register file rd1_addr.
- rf_rd0_data  input  16  from register file rd0_data.
- rf_rd1_data  input  16  from register file rd1_data.
- rf_wr_en  output  1  to register file wr_en.
- rf_wr_addr  output  3  to register file wr_addr.
- rf_wr_data  output  16  to register file wr_data.
- done  output  1  one-cycle pulse when an instruction retires.
- flag_z  output  1  zero flag.
- flag_c  output  1  carry/borrow flag.
- err  output  1  illegal-opcode indication.

Behaviour:
- Register file contract: read data is registered and updates only on an edge where wr_en=0. rf_wr_en must therefore be 0 during READ.
- FSM states: IDLE, READ, EXEC, WB.
  - IDLE: in_ready=1. Handshake (in_valid & in_ready) latches in_instr into instr_q and moves to READ.
  - READ: rf_rd0_addr=instr_q[8:6], rf_rd1_addr=instr_q[5:3], rf_wr_en=0. Next state EXEC.
  - EXEC: rf_rdX_data is valid. Compute result into result_q and flags into pending registers. Next state WB.
  - WB: rf_wr_en=1 for writing ops (0 for NOP/illegal), rf_wr_addr=instr_q[11:9], rf_wr_data=result_q. done=1. Flags commit. in_ready=1; a handshake in WB goes directly to READ, otherwise to IDLE.
- Latency: handshake edge to WB cycle is 3 cycles. Peak throughput is 1 instruction per 3 cycles when back-to-back.
- Read addresses hold their last value outside READ.
- in_ready=0 in READ and EXEC. in_instr is ignored there.
- Opcodes (all 16-bit, unsigned):
  - 0 NOP: no write, flags unchanged.
  - 1 ADD: rd = rs0 + rs1; c = carry out.
  - 2 SUB: rd = rs0 - rs1; c = borrow (rs0 < rs1).
  - 3 AND, 4 OR, 5 XOR: bitwise.
  - 6 NOT: rd = ~rs0.
  - 7 SHL: rd = rs0 << rs1[3:0].
  - 8 SHR: rd = rs0 >> rs1[3:0], logical.
  - 9 ADDI: rd = rs0 + zero-extended imm6; c = carry.
  - 10 LDI: rd = zero-extended imm9.
  - 11-15: illegal; no write, flags unchanged.
- Flag rules:
  - flag_z = (result == 0) for ops 1-10.
  - flag_c updates only for ADD/SUB/ADDI and holds for all other ops.
- err:
  - ILLEGAL_HALT=0: err pulses in the WB cycle of an illegal instruction.
  - ILLEGAL_HALT=1: err sets sticky in WB, FSM returns to IDLE with in_ready=0 until rst, and done still pulses for the illegal instruction.
- Writing rd equal to a source register is legal. Sources are sampled in READ, so the old value is used.
- Reset: state IDLE, in_ready=1, rf_wr_en=0, all addresses 0, rf_wr_data=0, done=0, flag_z=0, flag_c=0, err=0, instr_q=0, result_q=0.
- Reset mid-operation aborts the instruction: no write occurs on or after the reset edge.

Optional Feature:
- Macro: REG_EXEC_SAT_EN.
- Defined: ADD/ADDI clamp the result to 16'hFFFF on carry and SUB clamps to 16'h0000 on borrow. flag_c still reports the raw carry/borrow. flag_z is computed on the clamped value.
- Undefined: results wrap modulo 2^16.

Test Plan:
- rst, then preload r1=0xFFFF and r2=0x0001 via LDI/ADDI sequences. Then ADD r3,r1,r2 -> WB writes r3=0x0000, flag_z=1, flag_c=1, done pulses exactly 3 cycles after the handshake. With REG_EXEC_SAT_EN: r3=0xFFFF, flag_z=0.
- SUB r4,r2,r1 (0x0001-0xFFFF) -> r4=0x0002, flag_c=1. With SAT: r4=0x0000, flag_z=1.
- LDI r5,0x1AB then SHL r6,r5,r7 with r7=4 -> r6=0x1AB0. Check rf_wr_en=0 during every READ cycle.
- Back-to-back: in_valid held high with 4 ADDI instructions -> in_ready high only in IDLE/WB, 4 done pulses spaced 3 cycles apart, register writes in order.
- Opcode 0xC with ILLEGAL_HALT=0 -> err one-cycle pulse, no write, next instruction accepted. With ILLEGAL_HALT=1 -> err stays 1, in_ready stays 0 until rst.
- Assert rst during EXEC of ADD r3 -> no write to r3, all outputs at reset values next cycle, in_ready=1.
